regm2w: RTL and testbench

Parametrised two-write-port register memory for the pipelined CPU, successor to the single-write register memory. It adds a second write port for a separate writeback path (e.g. load return), configurable width and depth, an optional hardwired zero entry, and a post-reset clear sequencer that zeroes every entry before the block reports ready. It sits between decode (read ports) and writeback (write ports).

---
 rtl/regm2w.sv | 117 +++++++++++
 tb/tb_regm2w.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/regm2w.sv
// Two-write-port register memory with optional hardwired zero entry and a
// post-reset clear sequencer that zeroes every entry before raising ready.
module regm2w #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic [AW-1:0]    read1,
    input  logic [AW-1:0]    read2,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    input  logic             we_a,
    input  logic [AW-1:0]    wraddr_a,
    input  logic [WIDTH-1:0] wrdata_a,
    input  logic             we_b,
    input  logic [AW-1:0]    wraddr_b,
    input  logic [WIDTH-1:0] wrdata_b
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              wrEnA, wrEnB;
    logic [AW-1:0]     rdAddr [2];
    logic [WIDTH-1:0]  rdData [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // The edge that clears the last entry hands over to RUN; cnt wraps to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Write validity is shared by the store and the read bypass.
    assign wrEnA = we_a && (state_q == RUN) && !(ZERO_REG && (wraddr_a == '0));
    assign wrEnB = we_b && (state_q == RUN) && !(ZERO_REG && (wraddr_b == '0));

    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else begin
                if (wrEnA) begin
                    mem_q[wraddr_a] <= wrdata_a;
                end
                if (wrEnB) begin
                    mem_q[wraddr_b] <= wrdata_b;
                end
            end
        end
    end

    assign rdAddr[0] = read1;
    assign rdAddr[1] = read2;

    for (genvar p = 0; p < 2; p++) begin : g_read
        always_comb begin
            rdData[p] = mem_q[rdAddr[p]];
            if (state_q != RUN) begin
                rdData[p] = '0;
            end else if (ZERO_REG && (rdAddr[p] == '0)) begin
                rdData[p] = '0;
            end else if (wrEnB && (wraddr_b == rdAddr[p])) begin
                rdData[p] = wrdata_b;
            end else if (wrEnA && (wraddr_a == rdAddr[p])) begin
                rdData[p] = wrdata_a;
            end
        end
    end

    assign data1 = rdData[0];
    assign data2 = rdData[1];
    assign ready = ready_q;

endmodule

// File: tb/tb_regm2w.sv
// Directed self-checking bench for regm2w; a ZERO_REG=0 instance shares the
// stimulus so both zero-entry behaviours are exercised side by side.
module tb_regm2w;

    logic        clk;
    logic        rst;
    logic        ready, ready0;
    logic [4:0]  read1, read2;
    logic [31:0] data1, data2, data1z, data2z;
    logic        we_a, we_b;
    logic [4:0]  wraddr_a, wraddr_b;
    logic [31:0] wrdata_a, wrdata_b;

    int compareCount;
    int mismatchCount;

    regm2w #(.WIDTH(32), .AW(5), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .read1(read1), .read2(read2), .data1(data1), .data2(data2),
        .we_a(we_a), .wraddr_a(wraddr_a), .wrdata_a(wrdata_a),
        .we_b(we_b), .wraddr_b(wraddr_b), .wrdata_b(wrdata_b)
    );

    regm2w #(.WIDTH(32), .AW(5), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ready(ready0),
        .read1(read1), .read2(read2), .data1(data1z), .data2(data2z),
        .we_a(we_a), .wraddr_a(wraddr_a), .wrdata_a(wrdata_a),
        .we_b(we_b), .wraddr_b(wraddr_b), .wrdata_b(wrdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wea, input logic [4:0] aa, input logic [31:0] da,
                                 input logic web, input logic [4:0] ab, input logic [31:0] db);
        we_a = wea; wraddr_a = aa; wrdata_a = da;
        we_b = web; wraddr_b = ab; wrdata_b = db;
        #1;
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst = 1'b1;
        read1 = '0; read2 = '0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_data1", data1, 32'h0);

        // Writes attempted throughout the first clear must be ignored.
        rst = 1'b0;
        read1 = 5'd3; read2 = 5'd3;
        applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("clear_ready_%0d", i), {31'd0, ready}, 32'd0);
            checkOutput($sformatf("clear_data1_%0d", i), data1, 32'h0);
            tick();
        end
        checkOutput("clear_done_ready", {31'd0, ready}, 32'd1);
        checkOutput("clear_done_ready0", {31'd0, ready0}, 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("clear_write_dropped", data1, 32'h0);

        for (int a = 0; a < 32; a++) begin
            read1 = 5'(a); read2 = 5'(31 - a);
            #1;
            checkOutput($sformatf("cleared_d1_%0d", a), data1, 32'h0);
            checkOutput($sformatf("cleared_d2_%0d", a), data2, 32'h0);
        end

        read1 = 5'd7;
        applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 32'h0);
        checkOutput("bypass_a", data1, 32'h12345678);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("persist_a", data1, 32'h12345678);

        read1 = 5'd5; read2 = 5'd5;
        applyStimulus(1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd5, 32'h0000BBBB);
        checkOutput("collide_bypass_d1", data1, 32'h0000BBBB);
        checkOutput("collide_bypass_d2", data2, 32'h0000BBBB);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("collide_stored", data1, 32'h0000BBBB);

        // Port A bypass when port B targets a different address.
        read1 = 5'd9; read2 = 5'd10;
        applyStimulus(1'b1, 5'd9, 32'h00000099, 1'b1, 5'd10, 32'h000000AA);
        checkOutput("split_bypass_a", data1, 32'h00000099);
        checkOutput("split_bypass_b", data2, 32'h000000AA);
        tick();

        read2 = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
        checkOutput("zero_bypass", data2, 32'h0);
        checkOutput("nozero_bypass", data2z, 32'hFFFFFFFF);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("zero_stored", data2, 32'h0);
        checkOutput("nozero_stored", data2z, 32'hFFFFFFFF);

        applyStimulus(1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        read1 = 5'd1; read2 = 5'd4;
        #1;
        checkOutput("fill_r1", data1, 32'h11111111);
        checkOutput("fill_r4", data2, 32'h44444444);

        // Reset from RUN, with a write on the reset edge that must be lost.
        rst = 1'b1;
        applyStimulus(1'b1, 5'd6, 32'h66666666, 1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("rerun_ready_%0d", i), {31'd0, ready}, 32'd0);
            checkOutput($sformatf("rerun_data1_%0d", i), data1, 32'h0);
            tick();
        end
        checkOutput("rerun_done_ready", {31'd0, ready}, 32'd1);
        for (int a = 1; a <= 6; a++) begin
            read1 = 5'(a);
            #1;
            checkOutput($sformatf("rerun_cleared_%0d", a), data1, 32'h0);
        end
        read1 = 5'd0;
        #1;
        checkOutput("rerun_nozero_cleared", data1z, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
